input_mapper: RTL and testbench



---
 rtl/input_mapper_pkg.sv | 93 +++++++++
 rtl/input_mapper_coin_pulse.sv | 40 ++++
 rtl/input_mapper.sv | 163 ++++++++++++++++
 tb/tb_input_mapper.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_mapper_pkg.sv
// input_pkg: shared types, control-layout helpers and the default keymap
// for the input_mapper block.
package input_pkg;

  // {extended, scancode}
  typedef logic [8:0] keycode_t;

  localparam keycode_t UNMAPPED = 9'h000;

  // Direction slots sit below the action buttons and never move.
  localparam int CTRL_RIGHT = 0;
  localparam int CTRL_LEFT  = 1;
  localparam int CTRL_DOWN  = 2;
  localparam int CTRL_UP    = 3;

  function automatic int CTRL_W(input int buttons);
    return buttons + 32'sd8;
  endfunction

  function automatic int CTRL_BUTTON(input int n);
    return n + 32'sd4;
  endfunction

  function automatic int CTRL_START(input int buttons);
    return buttons + 32'sd4;
  endfunction

  function automatic int CTRL_COIN(input int buttons);
    return buttons + 32'sd5;
  endfunction

  function automatic int CTRL_PAUSE(input int buttons);
    return buttons + 32'sd6;
  endfunction

  function automatic int CTRL_SERVICE(input int buttons);
    return buttons + 32'sd7;
  endfunction

  // Default scancode for one control slot. Slots are folded onto an
  // 11-entry reference layout (4 dirs, 3 buttons, start/coin/pause/service);
  // buttons past the third and players past the second stay unmapped.
  function automatic keycode_t default_key(input int player, input int ctrl, input int buttons);
    logic [3:0] slot;
    logic [1:0] pl;
    keycode_t   code;
    pl = player[1:0];
    if (ctrl < 32'sd4) begin
      slot = ctrl[3:0];
    end else if (ctrl < 32'sd4 + buttons) begin
      if (ctrl < 32'sd7) slot = ctrl[3:0];
      else               slot = 4'd15;
    end else begin
      slot = 4'(ctrl - buttons + 32'sd3);
    end
    case (pl)
      2'd0: begin
        case (slot)
          4'd0:    code = 9'h174;
          4'd1:    code = 9'h16B;
          4'd2:    code = 9'h172;
          4'd3:    code = 9'h175;
          4'd4:    code = 9'h014;
          4'd5:    code = 9'h011;
          4'd6:    code = 9'h029;
          4'd7:    code = 9'h016;
          4'd8:    code = 9'h02E;
          4'd9:    code = 9'h04D;
          4'd10:   code = 9'h046;
          default: code = UNMAPPED;
        endcase
      end
      2'd1: begin
        case (slot)
          4'd0:    code = 9'h034;
          4'd1:    code = 9'h023;
          4'd2:    code = 9'h02B;
          4'd3:    code = 9'h02D;
          4'd4:    code = 9'h01C;
          4'd5:    code = 9'h01B;
          4'd6:    code = 9'h015;
          4'd7:    code = 9'h01E;
          4'd8:    code = 9'h036;
          4'd10:   code = 9'h045;
          default: code = UNMAPPED;
        endcase
      end
      default: code = UNMAPPED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/input_mapper_coin_pulse.sv
// coin_pulse: rising-edge one-shot. The pulse output is the value the
// consumer should register on this edge, so a registered copy rises on the
// same edge that sees the input edge and stays high COIN_PULSE cycles.
module coin_pulse #(
  parameter int COIN_PULSE = 16
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  localparam int CNT_W = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;

  // Cycles still to hold high after the current one.
  logic [CNT_W-1:0] cnt_r;
  logic             level_q_r;
  logic             rise_s;

  // Edge detect and pulse request; edges inside a running pulse are ignored.
  always_comb begin
    rise_s = level & ~level_q_r;
    if (cnt_r != {CNT_W{1'b0}}) pulse = 1'b1;
    else                        pulse = rise_s;
  end

  // Countdown and previous-level register.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      level_q_r <= 1'b0;
    end else begin
      level_q_r <= level;
      if (cnt_r != {CNT_W{1'b0}}) cnt_r <= cnt_r - 1'b1;
      else if (rise_s)            cnt_r <= CNT_W'(COIN_PULSE - 1);
      else                        cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/input_mapper.sv
// input_mapper: PS/2 + joystick to per-player arcade control vectors with a
// programmable keymap, coin one-shots and optional pause latching.
// Optional autofire on button 1 is built when INPUT_MAPPER_AUTOFIRE_EN is defined.
module input_mapper
  import input_pkg::*;
#(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 3,
  parameter int COIN_PULSE   = 16,
  parameter int PAUSE_TOGGLE = 1
`ifdef INPUT_MAPPER_AUTOFIRE_EN
  , parameter int AUTOFIRE_DIV = 4096
`endif
) (
  input  logic                                          clk_sys,
  input  logic                                          rst_n,
  input  logic [10:0]                                   ps2_key,
  input  logic [PLAYERS*CTRL_W(BUTTONS)-1:0]            joystick,
  input  logic                                          map_we,
  input  logic [$clog2(PLAYERS*CTRL_W(BUTTONS))-1:0]    map_idx,
  input  keycode_t                                      map_code,
`ifdef INPUT_MAPPER_AUTOFIRE_EN
  input  logic [PLAYERS-1:0]                            autofire,
`endif
  output logic [PLAYERS*CTRL_W(BUTTONS)-1:0]            ctrl
);

  localparam int CW      = CTRL_W(BUTTONS);
  localparam int NE      = PLAYERS * CW;
  localparam int IW      = $clog2(NE);
  localparam int B1_I    = CTRL_BUTTON(0);
  localparam int COIN_I  = CTRL_COIN(BUTTONS);
  localparam int PAUSE_I = CTRL_PAUSE(BUTTONS);
  localparam logic [IW:0] NE_L = (IW+1)'(NE);

  logic               old_toggle_r;
  logic               ev_valid_r;
  logic               ev_pressed_r;
  keycode_t           ev_code_r;
  keycode_t           keymap_r [NE];
  logic [NE-1:0]      key_state_r;
  logic [NE-1:0]      raw_s;
  logic [NE-1:0]      ctrl_next_s;
  logic [NE-1:0]      ctrl_r;
  logic [PLAYERS-1:0] coin_s;
  logic [PLAYERS-1:0] pause_raw_s;
  logic [PLAYERS-1:0] pause_next_s;
  logic [PLAYERS-1:0] pause_prev_r;
  logic [PLAYERS-1:0] pause_q_r;
  logic               map_ok_s;

  assign map_ok_s = map_we && ({1'b0, map_idx} < NE_L);
  assign raw_s    = key_state_r | joystick;
  assign ctrl     = ctrl_r;

  // Stage A: capture a key event whenever the hps_io toggle bit changes.
  // Reset reloads the toggle so the first post-reset cycle sees no event.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      old_toggle_r <= ps2_key[10];
      ev_valid_r   <= 1'b0;
      ev_pressed_r <= 1'b0;
      ev_code_r    <= UNMAPPED;
    end else begin
      old_toggle_r <= ps2_key[10];
      ev_valid_r   <= (ps2_key[10] != old_toggle_r);
      ev_pressed_r <= ps2_key[9];
      ev_code_r    <= {ps2_key[8], ps2_key[7:0]};
    end
  end

  // Stage B and keymap: parallel match against the pre-write table; a write
  // replaces its entry and drops that entry's held state.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        keymap_r[i] <= default_key(i / CW, i % CW, BUTTONS);
      end
      key_state_r <= {NE{1'b0}};
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (map_ok_s && (map_idx == IW'(i))) begin
          keymap_r[i]    <= map_code;
          key_state_r[i] <= 1'b0;
        end else if (ev_valid_r && (keymap_r[i] != UNMAPPED) && (keymap_r[i] == ev_code_r)) begin
          keymap_r[i]    <= keymap_r[i];
          key_state_r[i] <= ev_pressed_r;
        end else begin
          keymap_r[i]    <= keymap_r[i];
          key_state_r[i] <= key_state_r[i];
        end
      end
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
    coin_pulse #(.COIN_PULSE(COIN_PULSE)) u_coin (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .level   (raw_s[p*CW+COIN_I]),
      .pulse   (coin_s[p])
    );
  end

`ifdef INPUT_MAPPER_AUTOFIRE_EN
  localparam int AFW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  logic [AFW-1:0] af_cnt_r;
  logic           af_wave_r;

  // Shared autofire square wave, flipping every AUTOFIRE_DIV cycles.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      af_cnt_r  <= {AFW{1'b0}};
      af_wave_r <= 1'b0;
    end else if (af_cnt_r == AFW'(AUTOFIRE_DIV - 1)) begin
      af_cnt_r  <= {AFW{1'b0}};
      af_wave_r <= ~af_wave_r;
    end else begin
      af_cnt_r  <= af_cnt_r + 1'b1;
      af_wave_r <= af_wave_r;
    end
  end
`endif

  // Next control vector: merged inputs with coin, pause and autofire overrides.
  always_comb begin
    ctrl_next_s  = raw_s;
    pause_raw_s  = {PLAYERS{1'b0}};
    pause_next_s = pause_q_r;
    for (int p = 0; p < PLAYERS; p++) begin
      pause_raw_s[p] = raw_s[p*CW+PAUSE_I];
      if (PAUSE_TOGGLE != 0) begin
        if (pause_raw_s[p] && !pause_prev_r[p]) pause_next_s[p] = ~pause_q_r[p];
        else                                    pause_next_s[p] = pause_q_r[p];
        ctrl_next_s[p*CW+PAUSE_I] = pause_next_s[p];
      end else begin
        pause_next_s[p]           = pause_q_r[p];
        ctrl_next_s[p*CW+PAUSE_I] = pause_raw_s[p];
      end
      ctrl_next_s[p*CW+COIN_I] = coin_s[p];
`ifdef INPUT_MAPPER_AUTOFIRE_EN
      if (autofire[p]) ctrl_next_s[p*CW+B1_I] = raw_s[p*CW+B1_I] & af_wave_r;
      else             ctrl_next_s[p*CW+B1_I] = raw_s[p*CW+B1_I];
`else
      ctrl_next_s[p*CW+B1_I] = raw_s[p*CW+B1_I];
`endif
    end
  end

  // Output register plus pause latch and its edge-detect history.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      ctrl_r       <= {NE{1'b0}};
      pause_q_r    <= {PLAYERS{1'b0}};
      pause_prev_r <= {PLAYERS{1'b0}};
    end else begin
      ctrl_r       <= ctrl_next_s;
      pause_q_r    <= pause_next_s;
      pause_prev_r <= pause_raw_s;
    end
  end

endmodule

// File: tb/tb_input_mapper.sv
// tb_input_mapper: directed table, corner-case sequences and randomized
// traffic checked against a cycle-level behavioural model of input_mapper.
module tb_input_mapper;

  localparam int CW         = 11;
  localparam int NE         = 22;
  localparam int COIN_PULSE = 16;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic [10:0]   ps2_key;
  logic [NE-1:0] joystick;
  logic          map_we;
  logic [4:0]    map_idx;
  logic [8:0]    map_code;
  logic [NE-1:0] ctrl;
`ifdef INPUT_MAPPER_AUTOFIRE_EN
  logic [1:0]    autofire;
`endif

  always #5 clk_sys = ~clk_sys;

  input_mapper #(
    .PLAYERS(2), .BUTTONS(3), .COIN_PULSE(COIN_PULSE), .PAUSE_TOGGLE(1)
`ifdef INPUT_MAPPER_AUTOFIRE_EN
    , .AUTOFIRE_DIV(4)
`endif
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .ps2_key  (ps2_key),
    .joystick (joystick),
    .map_we   (map_we),
    .map_idx  (map_idx),
    .map_code (map_code),
`ifdef INPUT_MAPPER_AUTOFIRE_EN
    .autofire (autofire),
`endif
    .ctrl     (ctrl)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] def_map [NE] = '{
    9'h174, 9'h16B, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h016, 9'h02E, 9'h04D, 9'h046,
    9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015, 9'h01E, 9'h036, 9'h000, 9'h045};

  // behavioural model state
  logic [8:0]    m_map [NE];
  logic [NE-1:0] m_ks;
  logic [NE-1:0] exp_ctrl;
  logic [NE-1:0] af_mask = '0;
  logic          m_old, m_evv, m_evp;
  logic [8:0]    m_evc;
  int            cyc = 0;
  int            coin_end [2];
  logic [1:0]    coin_prev, pause_prev, pause_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_edge();
    logic [NE-1:0] raw;
    logic rc, rp;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) m_map[i] = def_map[i];
      m_ks = '0; exp_ctrl = '0; m_evv = 1'b0; m_old = ps2_key[10];
      for (int p = 0; p < 2; p++) begin
        coin_end[p] = 0; coin_prev[p] = 1'b0; pause_prev[p] = 1'b0; pause_lat[p] = 1'b0;
      end
    end else begin
      raw = m_ks | joystick;
      exp_ctrl = raw;
      for (int p = 0; p < 2; p++) begin
        rc = raw[p*CW+8];
        if (rc && !coin_prev[p] && cyc >= coin_end[p]) coin_end[p] = cyc + COIN_PULSE;
        exp_ctrl[p*CW+8] = (cyc < coin_end[p]);
        coin_prev[p] = rc;
        rp = raw[p*CW+9];
        if (rp && !pause_prev[p]) pause_lat[p] = ~pause_lat[p];
        exp_ctrl[p*CW+9] = pause_lat[p];
        pause_prev[p] = rp;
      end
      if (m_evv)
        for (int i = 0; i < NE; i++)
          if (m_map[i] != 9'h000 && m_map[i] == m_evc) m_ks[i] = m_evp;
      if (map_we && map_idx < NE) begin
        m_ks[map_idx]  = 1'b0;
        m_map[map_idx] = map_code;
      end
      m_evv = (ps2_key[10] != m_old);
      m_evp = ps2_key[9];
      m_evc = ps2_key[8:0];
      m_old = ps2_key[10];
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    chk("ctrl_vs_model", 32'(ctrl & ~af_mask), 32'(exp_ctrl & ~af_mask));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_key(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
    step();
  endtask

  function automatic logic [8:0] pick_code();
    int k;
    k = $urandom_range(0, 27);
    if (k < 22)      return def_map[k];
    else if (k < 24) return 9'h075;
    else if (k < 26) return 9'h01A;
    else             return 9'($urandom);
  endfunction

  typedef struct {
    logic [8:0] code;
    logic       pressed;
    int         bidx;
    logic       expv;
    string      name;
  } vec_t;
  vec_t vecs [12];

  task automatic set_vec(input int k, input logic [8:0] c, input logic pr, input int b,
                         input logic e, input string nm);
    vecs[k].code = c; vecs[k].pressed = pr; vecs[k].bidx = b; vecs[k].expv = e; vecs[k].name = nm;
  endtask

  int   hi, rises, trans, lastt;
  logic prev, last;

  initial begin
    set_vec(0,  9'h175, 1'b1, 3,  1'b1, "ext_up_press");
    set_vec(1,  9'h175, 1'b0, 3,  1'b0, "ext_up_release");
    set_vec(2,  9'h075, 1'b1, 3,  1'b0, "plain_75_no_match");
    set_vec(3,  9'h075, 1'b0, 3,  1'b0, "plain_75_release");
    set_vec(4,  9'h174, 1'b1, 0,  1'b1, "p1_right_press");
    set_vec(5,  9'h174, 1'b0, 0,  1'b0, "p1_right_release");
    set_vec(6,  9'h034, 1'b1, 11, 1'b1, "p2_right_press");
    set_vec(7,  9'h034, 1'b0, 11, 1'b0, "p2_right_release");
    set_vec(8,  9'h029, 1'b1, 6,  1'b1, "p1_b3_press");
    set_vec(9,  9'h029, 1'b0, 6,  1'b0, "p1_b3_release");
    set_vec(10, 9'h045, 1'b1, 21, 1'b1, "p2_service_press");
    set_vec(11, 9'h045, 1'b0, 21, 1'b0, "p2_service_release");

    rst_n = 1'b0; ps2_key = 11'h000; joystick = '0;
    map_we = 1'b0; map_idx = 5'd0; map_code = 9'h000;
`ifdef INPUT_MAPPER_AUTOFIRE_EN
    autofire = 2'b00;
`endif
    steps(3);
    chk("reset_ctrl", 32'(ctrl), 32'h0);
    rst_n = 1'b1;
    steps(2);

    // table-driven key events: event at edge 1, visible on ctrl at edge 3
    for (int k = 0; k < 12; k++) begin
      send_key(vecs[k].code, vecs[k].pressed);
      steps(2);
      chk(vecs[k].name, 32'(ctrl[vecs[k].bidx]), 32'(vecs[k].expv));
    end
    chk("all_released", 32'(ctrl), 32'h0);

    // coin held 100 cycles: one pulse of exactly COIN_PULSE cycles
    hi = 0; rises = 0; prev = 1'b0;
    send_key(9'h02E, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step();
      if (ctrl[8]) hi++;
      if (ctrl[8] && !prev) rises++;
      prev = ctrl[8];
    end
    chk("coin_hold_width", 32'(hi), 32'(COIN_PULSE));
    chk("coin_hold_pulses", 32'(rises), 32'd1);
    send_key(9'h02E, 1'b0);
    steps(20);

    // re-press inside a running pulse is ignored
    hi = 0; rises = 0; prev = 1'b0;
    ps2_key = {~ps2_key[10], 1'b1, 9'h02E};
    for (int i = 0; i < 60; i++) begin
      if (i == 7) ps2_key = {~ps2_key[10], 1'b0, 9'h02E};
      if (i == 8) ps2_key = {~ps2_key[10], 1'b1, 9'h02E};
      step();
      if (ctrl[8]) hi++;
      if (ctrl[8] && !prev) rises++;
      prev = ctrl[8];
    end
    chk("coin_repress_width", 32'(hi), 32'(COIN_PULSE));
    chk("coin_repress_pulses", 32'(rises), 32'd1);
    send_key(9'h02E, 1'b0);
    steps(20);

    // pause latch
    send_key(9'h04D, 1'b1); send_key(9'h04D, 1'b0); steps(3);
    chk("pause_first_press", 32'(ctrl[9]), 32'd1);
    send_key(9'h04D, 1'b1); send_key(9'h04D, 1'b0); steps(3);
    chk("pause_second_press", 32'(ctrl[9]), 32'd0);
    joystick[9] = 1'b1; steps(10);
    chk("pause_joy_held", 32'(ctrl[9]), 32'd1);
    joystick[9] = 1'b0; steps(3);
    chk("pause_joy_single", 32'(ctrl[9]), 32'd1);
    send_key(9'h04D, 1'b1); send_key(9'h04D, 1'b0); steps(3);
    chk("pause_back_off", 32'(ctrl[9]), 32'd0);

    // remap button 1 while its old key is held
    send_key(9'h014, 1'b1); steps(2);
    chk("remap_before", 32'(ctrl[4]), 32'd1);
    map_we = 1'b1; map_idx = 5'd4; map_code = 9'h01A;
    step();
    map_we = 1'b0;
    step();
    chk("remap_clears", 32'(ctrl[4]), 32'd0);
    send_key(9'h01A, 1'b1); steps(2);
    chk("remap_new_press", 32'(ctrl[4]), 32'd1);
    send_key(9'h01A, 1'b0); steps(2);
    chk("remap_new_release", 32'(ctrl[4]), 32'd0);
    send_key(9'h014, 1'b0);
    send_key(9'h014, 1'b1); steps(2);
    chk("remap_old_ignored", 32'(ctrl[4]), 32'd0);
    send_key(9'h014, 1'b0); steps(2);
    map_we = 1'b1; map_idx = 5'd25; map_code = 9'h014;
    step();
    map_we = 1'b0;

    // reset with a held key and a toggle flip during reset
    send_key(9'h034, 1'b1); steps(2);
    chk("reset_hold_pre", 32'(ctrl[11]), 32'd1);
    rst_n = 1'b0;
    ps2_key = {~ps2_key[10], 1'b1, 9'h034};
    step();
    rst_n = 1'b1;
    step();
    chk("reset_clears_ctrl", 32'(ctrl), 32'h0);
    steps(4);
    chk("reset_no_event", 32'(ctrl), 32'h0);
    send_key(9'h014, 1'b1); steps(2);
    chk("reset_default_map", 32'(ctrl[4]), 32'd1);
    send_key(9'h014, 1'b0);
    send_key(9'h034, 1'b0); steps(3);
    chk("reset_release_harmless", 32'(ctrl), 32'h0);

`ifdef INPUT_MAPPER_AUTOFIRE_EN
    af_mask = 22'h10; autofire = 2'b01; joystick = 22'h10;
    steps(6);
    last = ctrl[4]; lastt = 0; trans = 0;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (ctrl[4] != last) begin
        if (trans > 0) chk("af_gap", 32'(i - lastt), 32'd4);
        trans++; lastt = i; last = ctrl[4];
      end
    end
    chk("af_transitions", 32'(trans >= 10), 32'd1);
    joystick = '0; autofire = 2'b00;
    steps(2);
    af_mask = '0;
`endif

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), pick_code()};
      map_we   = ($urandom_range(0, 15) == 0);
      map_idx  = 5'($urandom_range(0, 31));
      map_code = pick_code();
      if ($urandom_range(0, 3) == 0)
        joystick = 22'($urandom) & 22'($urandom) & 22'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
